m_memarb: RTL

Two-port arbiter that lets the pipeline's instruction-fetch port and data-access port share one single-port synchronous memory (4K × 32, 1-cycle read latency, write on clock edge). It sits between the processor's IF/MEM stages and a single memory instance. It accepts one request per cycle, registers the winning request onto the memory inputs, and routes read data back to the owner with a valid pulse. Data port has priority; an optional age guard prevents fetch starvation.

---
 rtl/memarb_pkg.sv | 16 +
 rtl/m_memarb_age.sv | 32 +++
 rtl/m_memarb.sv | 97 +++++++++
 3 files changed

// File: rtl/memarb_pkg.sv
// memarb_pkg: return-tag type and default sizes shared by the
// m_memarb fetch/data memory arbiter and its age-guard counter.
package memarb_pkg;

    localparam int AW_DEF       = 12;
    localparam int DW_DEF       = 32;
    localparam int MAX_WAIT_DEF = 4;

    // Owner of a read travelling alongside the memory access
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IRD  = 2'd1,
        DRD  = 2'd2
    } tag_e;

endpackage

// File: rtl/m_memarb_age.sv
// m_memarb_age: counts consecutive cycles a pending fetch is denied and
// raises force_fetch once it has waited MAX_WAIT cycles.
module m_memarb_age
    import memarb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ireq,
    input  logic igrant,
    output logic force_fetch
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    assign force_fetch = ireq && (cnt == CW'(MAX_WAIT));

    // Age of the pending fetch; restarts whenever fetch wins or goes idle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!ireq || igrant) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/m_memarb.sv
// m_memarb: shares one single-port sync memory between fetch and data
// ports; data has priority. Define MEMARB_AGE_EN to add the fetch age guard.
module m_memarb
    import memarb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_ireq,
    input  logic [AW-1:0] w_iaddr,
    output logic          w_igrant,
    output logic          r_ivalid,
    output logic [DW-1:0] w_idata,
    input  logic          w_dreq,
    input  logic          w_dwe,
    input  logic [AW-1:0] w_daddr,
    input  logic [DW-1:0] w_ddin,
    output logic          w_dgrant,
    output logic          r_dvalid,
    output logic [DW-1:0] w_ddata,
    output logic [AW-1:0] r_maddr,
    output logic          r_mwe,
    output logic [DW-1:0] r_mdin,
    input  logic [DW-1:0] w_mdout
);

    if (MAX_WAIT < 1) begin : g_cfg_chk
        $error("m_memarb: MAX_WAIT must be at least 1");
    end

    logic force_fetch;
    tag_e tag1;
    tag_e tag2;

`ifdef MEMARB_AGE_EN
    m_memarb_age #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age (
        .clk        (w_clk),
        .rst        (w_rst),
        .ireq       (w_ireq),
        .igrant     (w_igrant),
        .force_fetch(force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // Grant: data wins unless the age guard forces the waiting fetch
    always_comb begin
        w_dgrant = 1'b0;
        w_igrant = 1'b0;
        if (!w_rst) begin
            if (w_dreq && !force_fetch) begin
                w_dgrant = 1'b1;
            end else if (w_ireq) begin
                w_igrant = 1'b1;
            end
        end
    end

    // Register the winner onto the memory pins and track read ownership
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_maddr <= '0;
            r_mwe   <= 1'b0;
            r_mdin  <= '0;
            tag1    <= NONE;
            tag2    <= NONE;
        end else begin
            tag2 <= tag1;
            if (w_dgrant) begin
                r_maddr <= w_daddr;
                r_mwe   <= w_dwe;
                r_mdin  <= w_ddin;
                tag1    <= w_dwe ? NONE : DRD;
            end else if (w_igrant) begin
                r_maddr <= w_iaddr;
                r_mwe   <= 1'b0;
                r_mdin  <= '0;
                tag1    <= IRD;
            end else begin
                r_mwe <= 1'b0;
                tag1  <= NONE;
            end
        end
    end

    assign r_ivalid = (tag2 == IRD);
    assign r_dvalid = (tag2 == DRD);
    assign w_idata  = w_mdout;
    assign w_ddata  = w_mdout;

endmodule
